// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmitter between NUM_REQ byte producers. A round-robin
// pointer selects the next requester, the accepted byte is latched and
// presented to the transmitter with a single-cycle start pulse, and the
// transmitter's busy flag is followed through the whole frame. If the
// transmitter never raises busy after a start pulse, the byte is dropped
// and a one-cycle timeout_err pulse is produced.
//
// Optional feature (macro UART_TX_SCHED_LOCK_EN):
//   Adds input req_lock[NUM_REQ-1:0]. When req_lock[grant_id] is high as a
//   frame completes, the pointer stays on that requester so a multi-byte
//   message is sent contiguously. A timeout always advances the pointer.
//
// Handshake (requester side): req_ready is a one-hot strobe driven
// combinationally in IDLE only, and only for a requester whose req_valid is
// high; a byte is transferred on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. There is no backpressure on the transmitter
// side: tx_start is a one-cycle pulse and tx_data is held until the next
// accept.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   req_valid    in   [NUM_REQ]            per-requester byte available
//   req_data     in   [NUM_REQ*DATA_BITS]  requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready    out  [NUM_REQ]            one-hot accept strobe (IDLE only)
//   tx_start     out                       one-cycle start pulse to transmitter
//   tx_data      out  [DATA_BITS]          latched byte for the transmitter
//   tx_busy      in                        transmitter frame in progress
//   grant_id     out  [$clog2(NUM_REQ)]    current / last granted requester
//   active       out                       high in every state except IDLE
//   timeout_err  out                       one-cycle pulse when busy never rose
//   req_lock     in   [NUM_REQ]            (only with UART_TX_SCHED_LOCK_EN)
//   dbg_state    out  [2]                  FSM state: 0 IDLE, 1 ISSUE,
//                                          2 WAIT_BUSY, 3 WAIT_DONE
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           active,
    output logic                           timeout_err,
`ifdef UART_TX_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic [1:0]                     dbg_state
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_grant_id;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic [CNT_W-1:0]       r_cnt;

    logic [PTR_W-1:0]       w_sel;
    logic                   w_any_valid;
    logic                   w_accept;
    logic                   w_timeout;
    logic [PTR_W-1:0]       w_grant_inc;
    logic                   w_hold;

    // -----------------------------------------------------------------------
    // Round-robin search: first valid requester at or above the pointer,
    // wrapping modulo NUM_REQ (not modulo 2**PTR_W).
    // -----------------------------------------------------------------------
    always_comb begin : sel_search
        int   v_idx;
        logic v_found;
        w_sel   = r_ptr;
        v_found = 1'b0;
        v_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!v_found && req_valid[v_idx[PTR_W-1:0]]) begin
                v_found = 1'b1;
                w_sel   = v_idx[PTR_W-1:0];
            end
        end
    end

    assign w_any_valid = |req_valid;

    // An external transmitter busy blocks any grant while idle.
    assign w_accept = (r_state == S_IDLE) && w_any_valid && !tx_busy;

    assign w_timeout = (r_state == S_WAIT_BUSY) && !tx_busy &&
                       (r_cnt == CNT_W'(START_TIMEOUT - 1));

    assign w_grant_inc = (r_grant_id == PTR_W'(NUM_REQ - 1)) ? '0
                                                             : r_grant_id + PTR_W'(1);

`ifdef UART_TX_SCHED_LOCK_EN
    assign w_hold = req_lock[r_grant_id];
`else
    assign w_hold = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next_state = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. Strobes are gated by reset so they drop in the same
    // cycle reset is asserted rather than one edge later.
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        active      = 1'b0;
        if (!reset) begin
            if (w_accept) begin
                req_ready[w_sel] = 1'b1;
            end
            tx_start    = (r_state == S_ISSUE);
            timeout_err = w_timeout;
        end
        active = (r_state != S_IDLE);
    end

    assign dbg_state = r_state;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;

    // -----------------------------------------------------------------------
    // Datapath: latched byte, grant index, round-robin pointer and the
    // start-timeout counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx_data  <= req_data[w_sel*DATA_BITS +: DATA_BITS];
                        r_grant_id <= w_sel;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (!tx_busy) begin
                        if (w_timeout) begin
                            // Dropped byte: the requester loses its turn even if locked.
                            r_ptr <= w_grant_inc;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        // A held lock parks the pointer on the current owner.
                        r_ptr <= w_hold ? r_grant_id : w_grant_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int NUM_REQ       = 4;
  localparam int DATA_BITS     = 8;
  localparam int START_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic                         clk;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_start;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_busy;
  logic [1:0]                   grant_id;
  logic                         active;
  logic                         timeout_err;
  logic [1:0]                   dbg_state;
`ifdef UART_TX_SCHED_LOCK_EN
  logic [NUM_REQ-1:0]           req_lock;
`endif

  int n_checks;
  int n_errors;
  int start_cnt;
  int overlap_cnt;
  int multi_ready_cnt;
  int waited;
  bit ok;
  int seen;
  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] exp_byte;

  uart_tx_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .DATA_BITS     (DATA_BITS),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err),
`ifdef UART_TX_SCHED_LOCK_EN
    .req_lock    (req_lock),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // protocol monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) start_cnt++;
      if (tx_start && tx_busy) overlap_cnt++;
      if ($countones(req_ready) > 1) multi_ready_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    tx_busy   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for tx_start; returns cycles waited.
  task automatic wait_start(input int budget, output int n, output bit found);
    n     = 0;
    found = 1'b0;
    while (n < budget && !found) begin
      if (tx_start) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  // Transmitter model: called in the ISSUE cycle; raises busy one cycle
  // later, holds it for len cycles, then drops it. Returns in WAIT_DONE.
  task automatic do_frame(input int len);
    tick();
    tx_busy = 1'b1;
    repeat (len) tick();
    tx_busy = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    start_cnt       = 0;
    overlap_cnt     = 0;
    multi_ready_cnt = 0;
    reset           = 1'b1;
    req_valid       = '0;
    req_data        = '0;
    tx_busy         = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
    req_lock        = '0;
`endif

    // ---------------- reset state ----------------
    tick();
    tick();
    req_valid = 4'b0001;
    #1;
    check("rst_active",    {31'd0, active},      32'd0);
    check("rst_tx_start",  {31'd0, tx_start},    32'd0);
    check("rst_ready",     {28'd0, req_ready},   32'd0);
    check("rst_timeout",   {31'd0, timeout_err}, 32'd0);
    check("rst_grant",     {30'd0, grant_id},    32'd0);
    check("rst_tx_data",   {24'd0, tx_data},     32'd0);
    check("rst_state",     {30'd0, dbg_state},   {30'd0, ST_IDLE});
    req_valid = '0;
    reset     = 1'b0;

    // ---------------- single request ----------------
    req_data  = {8'h33, 8'hA5, 8'h11, 8'h00};
    req_valid = 4'b0100;
    #1;
    check("single_ready", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    #1;
    check("single_start", {31'd0, tx_start}, 32'd1);
    check("single_data",  {24'd0, tx_data},  32'hA5);
    check("single_grant", {30'd0, grant_id}, 32'd2);
    check("single_state", {30'd0, dbg_state}, {30'd0, ST_ISSUE});
    do_frame(100);
    #1;
    check("single_active_done", {31'd0, active}, 32'd1);
    tick();
    check("single_active_idle", {31'd0, active},   32'd0);
    check("single_hold_data",   {24'd0, tx_data},  32'hA5);
    check("single_hold_grant",  {30'd0, grant_id}, 32'd2);
    check("single_starts",      start_cnt,         32'd1);

    // ---------------- all contend ----------------
    apply_reset();
    start_cnt = 0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    exp_q     = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    for (int k = 0; k < 5; k++) begin
      wait_start(10, waited, ok);
      check("rr_start_seen", {31'd0, ok}, 32'd1);
      if (k > 0) check("rr_gap", waited, 32'd2);
      exp_byte = exp_q.pop_front();
      check("rr_data",  {24'd0, tx_data},  {24'd0, exp_byte});
      check("rr_grant", {30'd0, grant_id}, k % 4);
      do_frame(5 + k);
    end
    req_valid = '0;
    tick();
    check("rr_start_count", start_cnt,   32'd5);
    check("rr_overlap",     overlap_cnt, 32'd0);

    // ---------------- timeout ----------------
    apply_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b0010;
    #1;
    check("to_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    check("to_start", {31'd0, tx_start}, 32'd1);
    seen = 0;
    for (int k = 1; k <= START_TIMEOUT + 8; k++) begin
      if (seen == 0) begin
        tick();
        if (timeout_err) seen = k;
      end
    end
    check("to_latency", seen, START_TIMEOUT);
    check("to_active_at_pulse", {31'd0, active}, 32'd1);
    tick();
    check("to_pulse_len",  {31'd0, timeout_err}, 32'd0);
    check("to_back_idle",  {30'd0, dbg_state},   {30'd0, ST_IDLE});
    req_valid = 4'b0111;
    #1;
    check("to_next_req2", {28'd0, req_ready}, 32'h4);
    req_valid = 4'b0011;
    #1;
    check("to_next_wrap", {28'd0, req_ready}, 32'h1);
    req_valid = '0;

    // ---------------- external busy ----------------
    apply_reset();
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (req_ready != '0 || active) seen++;
      tick();
    end
    check("ext_busy_no_grant", seen, 32'd0);
    tx_busy = 1'b0;
    #1;
    check("ext_busy_ready_same_cycle", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("ext_busy_grant", {30'd0, grant_id}, 32'd0);
    check("ext_busy_start", {31'd0, tx_start}, 32'd1);
    do_frame(3);
    tick();

    // ---------------- mid-frame reset ----------------
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("mfr_grant2", {30'd0, grant_id}, 32'd2);
    tick();
    tx_busy = 1'b1;
    tick();
    check("mfr_in_wait_done", {30'd0, dbg_state}, {30'd0, ST_WAIT_DONE});
    reset     = 1'b1;
    req_valid = 4'b1001;
    #1;
    check("mfr_ready_gated", {28'd0, req_ready}, 32'd0);
    tick();
    check("mfr_active",  {31'd0, active},      32'd0);
    check("mfr_grant",   {30'd0, grant_id},    32'd0);
    check("mfr_strobes", {29'd0, tx_start, timeout_err, |req_ready}, 32'd0);
    reset   = 1'b0;
    tx_busy = 1'b0;
    #1;
    check("mfr_ptr_zero", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("mfr_grant0_data", {24'd0, tx_data}, 32'hA0);
    do_frame(2);
    tick();

`ifdef UART_TX_SCHED_LOCK_EN
    // ---------------- lock ----------------
    apply_reset();
    req_data  = {8'h04, 8'h03, 8'h02, 8'h01};
    req_lock  = 4'b0001;
    req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_start(10, waited, ok);
      check("lock_start_seen", {31'd0, ok}, 32'd1);
      check("lock_grant0", {30'd0, grant_id}, 32'd0);
      if (k == 2) req_lock = '0;
      do_frame(3);
    end
    wait_start(10, waited, ok);
    check("lock_start_seen", {31'd0, ok}, 32'd1);
    check("lock_release_grant1", {30'd0, grant_id}, 32'd1);
    req_valid = '0;
    do_frame(3);
    tick();
`endif

    check("one_hot_ready", multi_ready_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ requesters.
- Accepts one byte per handshake from a requester and issues a single-cycle start pulse with the latched data to the transmitter.
- Tracks the transmitter's busy flag through the whole frame and handles a transmitter that never starts.
- Sits between on-chip byte producers and the UART transmit path, at the same level as the UART receiver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, width of one character; matches the UART frame width.
- START_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before aborting (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_BITS  packed bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_ready  output  NUM_REQ  one-hot, single-cycle accept strobe.
- tx_start  output  1  single-cycle start pulse to the transmitter.
- tx_data  output  DATA_BITS  byte to the transmitter; held stable from tx_start until the frame completes.
- tx_busy  input  1  transmitter frame in progress.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- active  output  1  high in every state except IDLE.
- timeout_err  output  1  single-cycle pulse when tx_busy fails to rise.

Behaviour:
- Reset values: all outputs 0. State is IDLE. Round-robin pointer is 0, so requester 0 has highest priority after reset.
- States are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE. All transitions occur on posedge clk.
- IDLE, when any req_valid is high and tx_busy is low:
  - Select the first valid requester searching upward (with wrap-around) from the pointer.
  - In the same cycle, assert req_ready[sel] combinationally, so the handshake completes when req_valid[sel] and req_ready[sel] are both high.
  - On that edge, latch req_data[sel] into tx_data and sel into grant_id, then go to ISSUE.
  - If tx_busy is high in IDLE (transmitter externally busy), no grant is made and the block stays in IDLE.
- ISSUE:
  - tx_start = 1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - On tx_busy = 1, go to WAIT_DONE.
  - Otherwise increment the timeout counter.
  - When the counter reaches START_TIMEOUT-1 with tx_busy still 0: pulse timeout_err for one cycle, advance the pointer to grant_id+1 (mod NUM_REQ), and go to IDLE. The byte is dropped, not retried.
- WAIT_DONE:
  - On tx_busy = 0, set the pointer to grant_id+1 (mod NUM_REQ) and go to IDLE.
- Latency:
  - Accept edge to tx_start high: 1 cycle.
  - End of frame (tx_busy falling) back to IDLE: 1 cycle.
  - Minimum gap between consecutive tx_start pulses: frame time + 3 cycles.
- Fairness: with all requesters valid continuously, grants go 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- Ignored inputs:
  - req_valid changes outside IDLE are ignored.
  - A requester that drops valid before being granted loses nothing; no state is kept per requester.
- Only one req_ready bit is ever high, and only in IDLE.
- tx_data and grant_id hold their values in IDLE after a frame, until the next accept.
- Reset asserted in any state returns to IDLE on the next edge:
  - tx_start, req_ready and timeout_err go low immediately.
  - The pointer returns to 0.
  - An in-flight frame is abandoned; the transmitter is not told.
- Pointer arithmetic: a modulo-NUM_REQ increment, so for NUM_REQ values that are not powers of 2 the pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: UART_TX_SCHED_LOCK_EN.
- When defined:
  - An extra input port req_lock, NUM_REQ bits wide, is added.
  - If req_lock[grant_id] is high when leaving WAIT_DONE, the pointer is not advanced. The same requester then has priority at the next IDLE if it is valid, which keeps multi-byte messages contiguous.
  - A timeout always advances the pointer, regardless of lock.
- When undefined: the port is absent and behaviour is pure round-robin as described above.

Test Plan:
- Single request: after reset, req_valid = 4'b0100 with byte 8'hA5.
  - req_ready = 4'b0100 for 1 cycle, then tx_start pulses with tx_data = 8'hA5 and grant_id = 2.
  - Transmitter model holds busy for 100 cycles; active falls 1 cycle after busy falls.
- All-contend: req_valid = 4'b1111 held, with distinct bytes 8'h10..8'h13.
  - Transmit order is 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
  - Exactly one tx_start per frame, and tx_start never occurs while tx_busy is high.
- Timeout: transmitter model never raises busy; requester 1 is valid.
  - timeout_err pulses START_TIMEOUT cycles after tx_start.
  - State returns to IDLE, and the next grant goes to requester 2 if it is valid, otherwise wraps.
- External busy: tx_busy forced high while req_valid = 4'b0001.
  - No req_ready while busy; grant occurs 0 cycles after tx_busy falls (same cycle req_ready = 4'b0001).
- Mid-frame reset: assert reset during WAIT_DONE.
  - Next cycle active = 0 and grant_id = 0, all strobes are 0, and requester 0 wins the next contention against requester 3.
- Lock (with UART_TX_SCHED_LOCK_EN): req_lock[0] = 1 and req_valid = 4'b0011.
  - Three consecutive grants go to requester 0.
  - After req_lock[0] drops, the next grant goes to requester 1.
